// File: rtl/bus_ram_loader_if.sv
// ---------------------------------------------------------------------------
// bus_ram_loader_if
// Control and handshake bundle for bus_ram_loader.
//   CPU side     : addr, we, oe
//   Commands     : clr_req (zero-fill), ld_start/ld_base (stream load)
//   Stream       : ld_valid, ld_data, ld_last -> ld_ready
//   Status       : busy, done
// The shared tri-state data bus is a plain inout port on the RAM itself, so
// the resolved net stays a real port rather than a member of a bundle.
// Modports: master = CPU/stream source, slave = the RAM loader.
// ---------------------------------------------------------------------------
interface bus_ram_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              oe;
  logic              clr_req;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              busy;
  logic              done;

  modport master (
    output addr, we, oe, clr_req, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  ld_ready, busy, done
  );

  modport slave (
    input  addr, we, oe, clr_req, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output ld_ready, busy, done
  );
endinterface

// File: rtl/bus_ram_loader.sv
// ---------------------------------------------------------------------------
// bus_ram_loader
// Parametrised bus RAM for the 8-bit computer with a hardware zero-fill
// sequencer and a streaming valid/ready program loader.
// Ports:
//   clk   - system clock, all state on the rising edge
//   rst   - asynchronous active-high reset
//   bus   - bus_ram_loader_if.slave: CPU addr/we/oe, clr_req, ld_* stream,
//           ld_ready, busy, done
//   data  - shared tri-state CPU data bus (written on clock, buffered read
//           driven only while idle, output-enabled and not writing)
// ---------------------------------------------------------------------------
module bus_ram_loader #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int CLEAR_ON_RST = 0
) (
  input  logic               clk,
  input  logic               rst,
  bus_ram_loader_if.slave    bus,
  inout  wire  [DATA_W-1:0]  data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W-1:0] buffer_reg;
  logic              done_reg, done_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RST_STATE;
      ptr_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      done_reg  <= done_next;
    end
  end

  // Next-state / write-port selection
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    done_next  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ptr_reg;
    mem_wdata  = '0;
    rd_en      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // Commands win over the CPU access issued in the same cycle.
        if (bus.clr_req) begin
          ptr_next   = '0;
          state_next = ST_CLEAR;
        end else if (bus.ld_start) begin
          ptr_next   = bus.ld_base;
          state_next = ST_LOAD;
        end else if (bus.we) begin
          mem_we    = 1'b1;
          mem_waddr = bus.addr;
          mem_wdata = data;
        end else begin
          rd_en = 1'b1;
        end
      end

      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_reg;
        mem_wdata = '0;
        ptr_next  = ptr_reg + ADDR_W'(1);
        // Last word of the array written this cycle.
        if (&ptr_reg) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end

      ST_LOAD: begin
        if (bus.ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_reg;
          mem_wdata = bus.ld_data;
          ptr_next  = ptr_reg + ADDR_W'(1);  // wraps modulo DEPTH
          if (bus.ld_last) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Memory array: contents survive reset, but no write may land while reset
  // is held (the FSM is already forced to its reset state then).
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read buffer; holds its value unless an idle read occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer_reg <= '0;
    end else if (rd_en) begin
      buffer_reg <= mem[bus.addr];
    end
  end

  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = done_reg;
  assign bus.ld_ready = (state_reg == ST_LOAD);

  // The bus is only driven while idle, so a sequencer can never collide
  // with the CPU or another bus driver.
  assign data = ((state_reg == ST_IDLE) && bus.oe && !bus.we) ? buffer_reg
                                                              : {DATA_W{1'bz}};

endmodule

// File: doc/bus_ram_loader.md
Name: bus_ram_loader

Overview:
- Parametrised successor to the 8-bit computer's 256x8 bus RAM.
- Keeps the shared tri-state data bus: write on clock, buffered read driven when output-enabled.
- Adds configurable width and depth, asynchronous reset, a hardware zero-fill (clear) sequencer, and a streaming valid/ready loader.
- Program images can be loaded at run time instead of only at elaboration. The block sits on the CPU bus in place of the fixed RAM.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- CLEAR_ON_RST, 0, if 1 the FSM enters CLEAR on reset release instead of IDLE.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- addr  in  ADDR_W  CPU bus address.
- we  in  1  CPU write strobe (1 = write data to mem[addr]; 0 = read into buffer).
- oe  in  1  CPU output enable for the data bus.
- data  inout  DATA_W  shared tri-state CPU data bus.
- clr_req  in  1  request zero-fill of the whole array.
- ld_start  in  1  start a stream load at ld_base.
- ld_base  in  ADDR_W  first address of the stream load, sampled when ld_start is accepted.
- ld_valid  in  1  stream beat valid.
- ld_data  in  DATA_W  stream beat payload.
- ld_last  in  1  final beat of the stream, qualified by ld_valid.
- ld_ready  out  1  loader can accept a beat.
- busy  out  1  FSM is not IDLE.
- done  out  1  one-cycle pulse when CLEAR or LOAD completes.

Behaviour:
- Reset (asynchronous, immediate):
  - state = CLEAR if CLEAR_ON_RST else IDLE; ptr = 0; buffer = 0.
  - busy = CLEAR_ON_RST; done = 0; ld_ready = 0; data = Z.
  - Memory contents are not reset.
- Reset asserted mid-CLEAR or mid-LOAD aborts the operation. Words already written keep their new values; no done pulse.
- State IDLE, accepting a command:
  - Priority: clr_req > ld_start > CPU access.
  - clr_req: ptr <= 0, go to CLEAR; the CPU write in the same cycle is dropped.
  - ld_start (without clr_req): ptr <= ld_base, go to LOAD; the CPU write is dropped.
- State IDLE, no command:
  - we=1: mem[addr] <= data.
  - we=0: buffer <= mem[addr]. Read latency is 1 cycle; buffer holds its value otherwise.
- Data bus drive:
  - data = buffer only when state==IDLE && oe && !we; otherwise Z.
  - The bus is never driven while busy.
- State CLEAR:
  - Each cycle mem[ptr] <= 0, ptr++.
  - The cycle ptr==DEPTH-1 is written, then the FSM goes to IDLE with done=1 for the next cycle.
  - Total DEPTH busy cycles.
- State LOAD:
  - ld_ready = 1 throughout.
  - On ld_valid: mem[ptr] <= ld_data; ptr <= ptr+1, wrapping modulo DEPTH (DEPTH-1 -> 0).
  - On ld_valid && ld_last: go to IDLE, done=1 for the next cycle.
  - ld_valid=0 stalls with no write.
  - A stream longer than DEPTH overwrites earlier words; this is legal.
- While busy:
  - CPU we, oe, clr_req and ld_start are ignored, and buffer holds.
- ld_ready is 0 outside LOAD; ld_valid outside LOAD is ignored.
- done is registered and asserts for exactly 1 cycle. busy deasserts in the same cycle done asserts.
- Widths: ptr is ADDR_W bits with natural wrap; no overflow flag.

Test Plan:
- Reset with CLEAR_ON_RST=0 -> busy=0, done=0, ld_ready=0, data=Z. Then write 0xA5 to addr 0x10, read with oe=1 -> data=0xA5 one cycle after the read edge; data=Z when oe=0.
- CLEAR_ON_RST=1, ADDR_W=4, preload all 16 words with 0xFF -> busy high for 16 cycles, done pulses once, all 16 words read back 0x00.
- ld_start with ld_base=0xFE, stream 0x11, 0x22, 0x33, 0x44 (last on 0x44), ld_valid gapped every other cycle -> mem[FE]=11, mem[FF]=22, mem[00]=33, mem[01]=44 (wrap); done pulses once after the last beat.
- clr_req, ld_start and we=1 (addr 0x05, data 0x77) in the same IDLE cycle -> CLEAR runs; mem[05]=0x00 afterwards, no LOAD.
- Assert oe=1, we=0 during LOAD -> data stays Z and buffer is unchanged. Assert rst after 2 of 4 beats -> busy=0 immediately, first 2 words written, remaining words unchanged, no done.
- DATA_W=16, ADDR_W=10: write 0xBEEF to 0x3FF, read it back -> data=0xBEEF. Stream 3 beats starting at 0x3FF -> writes land at 0x3FF, 0x000, 0x001.
